// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the seven-segment display path
// (scanner, refresh tick, cathode decoder and their benches).
package seg_disp_pkg;
  localparam int SEG_NUM_DIGITS      = 8;
  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam logic [SEG_NUM_DIGITS-1:0] ANODE_ALL_OFF = '1;

  // Refresh counter width; a divider of 2 still needs one bit.
  function automatic int refresh_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/seg_scan_mux_if.sv
// Scanner-side bus: packed BCD digits and enables in, anode/count/slot tick out.
// Macro SEG_BLINK_EN adds the blink_mask signal.
interface seg_scan_mux_if
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = SEG_NUM_DIGITS
) ();
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      digit_en;
`ifdef SEG_BLINK_EN
  logic [NUM_DIGITS-1:0]      blink_mask;
`endif
  logic [NUM_DIGITS-1:0]      anode;
  logic [3:0]                 count;
  logic                       slot_tick;

`ifdef SEG_BLINK_EN
  modport master (output digits, digit_en, blink_mask, input anode, count, slot_tick);
  modport slave  (input digits, digit_en, blink_mask, output anode, count, slot_tick);
`else
  modport master (output digits, digit_en, input anode, count, slot_tick);
  modport slave  (input digits, digit_en, output anode, count, slot_tick);
`endif
endinterface

// File: rtl/seg_refresh_tick.sv
// Modulo-DIV slot counter: registered tick while the counter holds DIV-1,
// plus combinational wrap / pre_last flags for the scanner.
module seg_refresh_tick
  import seg_disp_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic wrap,
  output logic pre_last
);
  localparam int CW = refresh_cnt_w(DIV);

  logic [CW-1:0] cnt;

  assign wrap     = (cnt == CW'(DIV - 1));
  // Counter will hold DIV-1 after the coming edge.
  assign pre_last = (cnt == CW'(DIV - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      tick <= pre_last;
    end
  end
endmodule

// File: rtl/seg_scan_mux.sv
// 8-digit common-anode scanner: rotates one active-low anode per refresh slot
// and drives the matching BCD nibble on count. Macro SEG_BLINK_EN adds blinking.
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = SEG_NUM_DIGITS,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int BLINK_SLOTS = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  seg_scan_mux_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF      = ANODE_ALL_OFF[NUM_DIGITS-1:0];

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLINK_SLOTS < 1) begin : g_bad_cfg
    $error("seg_scan_mux: illegal parameter set");
  end

  logic                  tick, wrap, pre_last;
  logic [IW-1:0]         idx;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [3:0]            count_q;
  logic                  blink_dark;
  logic                  dark;

  seg_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (reset_n),
    .tick     (tick),
    .wrap     (wrap),
    .pre_last (pre_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  idx <= '0;
    else if (wrap) idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  logic [FW-1:0] frame_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (wrap && idx == LAST_IDX) begin
      if (frame_cnt == FW'(BLINK_SLOTS - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign blink_dark = phase & bus.blink_mask[idx];
`else
  assign blink_dark = 1'b0;
`endif

  // Ghost guard keys on the counter's next value so the dark cycle lines up
  // with the counter holding REFRESH_DIV-1; the digit itself lags idx by one.
  assign sel  = NUM_DIGITS'(1) << idx;
  assign dark = pre_last | ~bus.digit_en[idx] | blink_dark;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode_q <= OFF;
      count_q <= 4'h0;
    end else begin
      anode_q <= dark ? OFF : ~sel;
      count_q <= bus.digits[idx];
    end
  end

  assign bus.anode     = anode_q;
  assign bus.count     = count_q;
  assign bus.slot_tick = tick;
endmodule
